br_resolve_queue: RTL and testbench
===================================

// Module: br_resolve_queue
// PURPOSE
//  Resolution end of the fetch-time branch predictor. Every instruction leaving IF pushes its
//  BTB prediction (taken, target) with its PC into an in-order queue. Every WB retirement pops
//  the oldest entry and checks it against the actual outcome (pc_sel_out_sel, pc_mux_out).
//  On a wrong prediction it raises flush plus redirect PC, squashes younger entries, and issues
//  the BTB write strobe (pc_wb, target) that the BTB consumes at WB.
// PARAMETERS
//  DEPTH  4   in-flight entries; power of 2, >=2
//  AW     2   log2(DEPTH); pointer width (count is AW+1 bits)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  reset           in   1   asynchronous, active-high reset
//  if_valid        in   1   instruction leaves IF this cycle -> push
//  pc_if           in   16  PC of that instruction
//  pred_taken      in   1   BTB hit at IF (predicted taken)
//  pred_target     in   16  BTB branch_address for that instruction
//  wb_valid        in   1   instruction retires in WB this cycle -> pop
//  opcode_wb       in   4   lc3b opcode at WB; BR = 4'b0000
//  pc_wb           in   16  PC at WB
//  pc_sel_out_sel  in   1   actual branch taken at WB
//  pc_mux_out      in   16  actual target at WB
//  flush           out  1   1-cycle pulse: squash IF..MEM, fetch from redirect_pc
//  redirect_pc     out  16  correct next PC, valid with flush
//  btb_update      out  1   1-cycle pulse: write (update_pc, update_target) into BTB
//  update_pc       out  16  tag/index source for BTB write
//  update_target   out  16  branch address for BTB write
//  full / empty    out  1   queue status, combinational from count
//  order_err       out  1   sticky: popped entry PC != pc_wb, or pop while empty
//  overflow        out  1   sticky: push while full with no simultaneous pop
//  mispredict_cnt  out  16  saturating count of flushes
// BEHAVIOUR
//  Reset, async at any time including mid-flight: queue emptied (rd/wr ptr=0, count=0).
//   Outputs: flush=0, redirect_pc=0, btb_update=0, update_pc=0, update_target=0,
//   order_err=0, overflow=0, mispredict_cnt=0. Resulting status: empty=1, full=0.
//  Queue: circular buffer, pointers wrap modulo DEPTH. push = if_valid and not dropped.
//   pop = wb_valid and count!=0. Simultaneous push+pop is legal at any count, including full;
//   count is unchanged.
//  Full and if_valid with no pop: push dropped and overflow set. Empty and wb_valid: entry is
//   treated as {pred_taken=0, pred_target=0, pc=pc_wb}, and order_err is set.
//  Check at WB (combinational on the popped entry; all outputs registered -> 1-cycle latency):
//   is_br = opcode_wb==4'b0000.
//   mis = is_br ? (pred_taken!=pc_sel_out_sel) | (pred_taken & pc_sel_out_sel & pred_target!=pc_mux_out)
//              : pred_taken
//  Cycle N with wb_valid & mis, registered at edge N+1:
//   flush=1.
//   redirect_pc = (is_br & pc_sel_out_sel) ? pc_mux_out : pc_wb+16'd2 (mod 2^16 wrap).
//   Queue cleared at the same edge. A push requested in cycle N is discarded because it is
//    wrong-path.
//   mispredict_cnt increments; it holds at 16'hFFFF.
//  btb_update=1 at edge N+1 iff wb_valid & is_br & pc_sel_out_sel & mis.
//   Then update_pc=pc_wb and update_target=pc_mux_out. Otherwise btb_update=0 and
//   update_* hold their values.
//  Correct predictions: no flush, no update, pop only. flush/btb_update never stay high for
//   2 cycles from one event.
//  Pushes in cycle N+1 (post-flush fetch at redirect_pc) are accepted normally.
//  order_err/overflow clear only on reset.
// TESTING
//  T1 reset mid-flight: 3 pushes, assert reset async -> empty=1, all outputs 0 before next edge.
//  T2 correct taken BR: push pc 0x3000 pred 1/0x3010; pop BR taken 0x3010 -> flush=0, btb_update=0, empty=1.
//  T3 wrong target: pred 1/0x3010, actual taken 0x3020 -> next cycle flush=1, redirect 0x3020, btb_update=1 (0x3000,0x3020), cnt=1.
//  T4 predicted taken, non-BR (ADD) at 0xFFFE -> flush=1, redirect_pc=0x0000 (wrap), btb_update=0.
//  T5 fill DEPTH, push again no pop -> overflow=1, count=DEPTH; then push+pop same cycle -> count stays DEPTH.
//  T6 mispredict pop with concurrent push and 2 younger entries -> after edge empty=1, pushed entry absent.

Source files
------------

// File: rtl/br_resolve_queue.sv
// ---------------------------------------------------------------------------
// br_resolve_queue
//
// This is the resolution end of the fetch-time branch predictor. Each
// instruction that leaves IF pushes its BTB prediction and its PC into an
// in-order circular queue. Each WB retirement pops the oldest entry and
// compares it with the real outcome. On a wrong prediction the module:
//   - raises flush for one cycle, together with the correct redirect PC,
//   - empties the queue, because every younger entry is wrong-path,
//   - and, for a taken BR, issues a one-cycle BTB write strobe.
// Every output is registered, so each output appears one cycle after the
// retirement that caused it.
//
// Ports
//   clk, reset                   clock; asynchronous active-high reset
//   if_valid, pc_if,             push request from IF: the PC and the BTB
//   pred_taken, pred_target        prediction for that instruction
//   wb_valid, opcode_wb, pc_wb,  pop request from WB: the opcode, the PC,
//   pc_sel_out_sel, pc_mux_out     the actual taken bit and the actual target
//   flush, redirect_pc           mispredict pulse and correct next PC
//   btb_update, update_pc,       BTB write strobe, plus the tag/index and
//   update_target                  the target to write
//   full, empty                  queue status, decoded from the count
//   order_err, overflow          sticky error flags; only reset clears them
//   mispredict_cnt               saturating count of flushes
//
// Handshake: neither push nor pop has backpressure. if_valid and wb_valid
// are both qualified by the current clock edge alone. A push is dropped
// when the queue is full and no pop happens in the same cycle. A push is
// also dropped in a cycle that flushes. A pop is performed only when the
// queue holds at least one entry.
// ---------------------------------------------------------------------------
module br_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [15:0] pc_if,
  input  logic        pred_taken,
  input  logic [15:0] pred_target,
  input  logic        wb_valid,
  input  logic [3:0]  opcode_wb,
  input  logic [15:0] pc_wb,
  input  logic        pc_sel_out_sel,
  input  logic [15:0] pc_mux_out,
  output logic        flush,
  output logic [15:0] redirect_pc,
  output logic        btb_update,
  output logic [15:0] update_pc,
  output logic [15:0] update_target,
  output logic        full,
  output logic        empty,
  output logic        order_err,
  output logic        overflow,
  output logic [15:0] mispredict_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  OP_BR    = 4'b0000;

  // Queue storage. It is never read while it is empty, so it has no reset.
  logic [15:0] pc_mem_q     [DEPTH];
  logic [15:0] target_mem_q [DEPTH];
  logic        taken_mem_q  [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic        flush_q, flush_d;
  logic [15:0] redirect_pc_q, redirect_pc_d;
  logic        btb_update_q, btb_update_d;
  logic [15:0] update_pc_q, update_pc_d;
  logic [15:0] update_target_q, update_target_d;
  logic        order_err_q, order_err_d;
  logic        overflow_q, overflow_d;
  logic [15:0] mispredict_cnt_q, mispredict_cnt_d;

  logic        q_empty, q_full;
  logic        pop, push, push_drop_full;
  logic        ent_taken;
  logic [15:0] ent_target, ent_pc;
  logic        is_br, mis, mis_ev;

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == FULL_CNT);

  always_comb begin
    pop = wb_valid & ~q_empty;

    // A pop from an empty queue is checked as if the entry were a
    // not-taken prediction carrying the WB PC.
    ent_taken  = 1'b0;
    ent_target = 16'h0000;
    ent_pc     = pc_wb;
    if (pop) begin
      ent_taken  = taken_mem_q[rd_ptr_q];
      ent_target = target_mem_q[rd_ptr_q];
      ent_pc     = pc_mem_q[rd_ptr_q];
    end

    is_br = (opcode_wb == OP_BR);
    if (is_br) begin
      mis = (ent_taken != pc_sel_out_sel) |
            (ent_taken & pc_sel_out_sel & (ent_target != pc_mux_out));
    end else begin
      mis = ent_taken;
    end
    mis_ev = wb_valid & mis;

    push_drop_full = if_valid & q_full & ~pop;
    // A push in the flushing cycle comes from the wrong path, so it is dropped.
    push = if_valid & ~push_drop_full & ~mis_ev;
  end

  always_comb begin
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    flush_d          = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    btb_update_d     = 1'b0;
    update_pc_d      = update_pc_q;
    update_target_d  = update_target_q;
    order_err_d      = order_err_q;
    overflow_d       = overflow_q;
    mispredict_cnt_d = mispredict_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (push_drop_full) overflow_d = 1'b1;
    if (wb_valid & (q_empty | (ent_pc != pc_wb))) order_err_d = 1'b1;

    if (mis_ev) begin
      flush_d       = 1'b1;
      redirect_pc_d = (is_br & pc_sel_out_sel) ? pc_mux_out : (pc_wb + 16'd2);
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      if (mispredict_cnt_q != 16'hFFFF) mispredict_cnt_d = mispredict_cnt_q + 16'd1;
      // Only a taken BR carries a target that is worth writing into the BTB.
      if (is_br & pc_sel_out_sel) begin
        btb_update_d    = 1'b1;
        update_pc_d     = pc_wb;
        update_target_d = pc_mux_out;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= 16'h0000;
      btb_update_q     <= 1'b0;
      update_pc_q      <= 16'h0000;
      update_target_q  <= 16'h0000;
      order_err_q      <= 1'b0;
      overflow_q       <= 1'b0;
      mispredict_cnt_q <= 16'h0000;
    end else begin
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
      btb_update_q     <= btb_update_d;
      update_pc_q      <= update_pc_d;
      update_target_q  <= update_target_d;
      order_err_q      <= order_err_d;
      overflow_q       <= overflow_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]     <= pc_if;
      target_mem_q[wr_ptr_q] <= pred_target;
      taken_mem_q[wr_ptr_q]  <= pred_taken;
    end
  end

  assign flush          = flush_q;
  assign redirect_pc    = redirect_pc_q;
  assign btb_update     = btb_update_q;
  assign update_pc      = update_pc_q;
  assign update_target  = update_target_q;
  assign full           = q_full;
  assign empty          = q_empty;
  assign order_err      = order_err_q;
  assign overflow       = overflow_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_br_resolve_queue.sv
module tb_br_resolve_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [15:0] pc_if = '0;
  logic        pred_taken = 1'b0;
  logic [15:0] pred_target = '0;
  logic        wb_valid = 1'b0;
  logic [3:0]  opcode_wb = '0;
  logic [15:0] pc_wb = '0;
  logic        pc_sel_out_sel = 1'b0;
  logic [15:0] pc_mux_out = '0;
  logic        flush, btb_update, full, empty, order_err, overflow;
  logic [15:0] redirect_pc, update_pc, update_target, mispredict_cnt;

  br_resolve_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .pc_if(pc_if),
    .pred_taken(pred_taken), .pred_target(pred_target), .wb_valid(wb_valid),
    .opcode_wb(opcode_wb), .pc_wb(pc_wb), .pc_sel_out_sel(pc_sel_out_sel),
    .pc_mux_out(pc_mux_out), .flush(flush), .redirect_pc(redirect_pc),
    .btb_update(btb_update), .update_pc(update_pc), .update_target(update_target),
    .full(full), .empty(empty), .order_err(order_err), .overflow(overflow),
    .mispredict_cnt(mispredict_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: reference model
  typedef struct {
    logic        taken;
    logic [15:0] target;
    logic [15:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic        m_flush, m_upd, m_oerr, m_ovf;
  logic [15:0] m_redir, m_upd_pc, m_upd_tgt;
  int          m_cnt;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_clear();
    mq.delete();
    m_flush = 0; m_upd = 0; m_oerr = 0; m_ovf = 0;
    m_redir = 0; m_upd_pc = 0; m_upd_tgt = 0; m_cnt = 0;
  endtask

  // Advances the model by one cycle, using the inputs currently being driven.
  task automatic model_step();
    ent_t        e;
    logic        mis, isbr;
    logic [15:0] nxt;
    mis  = 0;
    isbr = (opcode_wb == 4'd0);
    if (wb_valid) begin
      if (mq.size() > 0) e = mq.pop_front();
      else begin
        e.taken = 0; e.target = 0; e.pc = pc_wb; m_oerr = 1;
      end
      if (e.pc != pc_wb) m_oerr = 1;
      if (isbr) mis = (e.taken != pc_sel_out_sel) ||
                      (e.taken && pc_sel_out_sel && e.target != pc_mux_out);
      else      mis = e.taken;
    end
    m_flush = wb_valid && mis;
    m_upd   = m_flush && isbr && pc_sel_out_sel;
    if (m_flush) begin
      nxt = pc_wb + 16'd2;
      m_redir = (isbr && pc_sel_out_sel) ? pc_mux_out : nxt;
      mq.delete();
      if (m_cnt < 65535) m_cnt++;
    end
    if (m_upd) begin
      m_upd_pc = pc_wb; m_upd_tgt = pc_mux_out;
    end
    if (if_valid && !m_flush) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else begin
        e.taken = pred_taken; e.target = pred_target; e.pc = pc_if;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_model();
    chk("flush", flush, m_flush);
    if (m_flush) chk("redirect_pc", redirect_pc, m_redir);
    chk("btb_update", btb_update, m_upd);
    chk("update_pc", update_pc, m_upd_pc);
    chk("update_target", update_target, m_upd_tgt);
    chk("order_err", order_err, m_oerr);
    chk("overflow", overflow, m_ovf);
    chk("mispredict_cnt", mispredict_cnt, m_cnt[15:0]);
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
  endtask

  // driver: one clock cycle of stimulus, then the check of the registered outputs
  task automatic cyc(input logic ifv, input logic [15:0] pci, input logic pt,
                     input logic [15:0] ptg, input logic wbv, input logic [3:0] op,
                     input logic [15:0] pcw, input logic sel, input logic [15:0] mux);
    @(negedge clk);
    if_valid = ifv; pc_if = pci; pred_taken = pt; pred_target = ptg;
    wb_valid = wbv; opcode_wb = op; pc_wb = pcw; pc_sel_out_sel = sel; pc_mux_out = mux;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    if_valid = 0; pc_if = 0; pred_taken = 0; pred_target = 0;
    wb_valid = 0; opcode_wb = 0; pc_wb = 0; pc_sel_out_sel = 0; pc_mux_out = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    model_clear();
    @(negedge clk);
    reset = 0;
  endtask

  typedef struct {
    logic        ifv;
    logic [15:0] pci;
    logic        pt;
    logic [15:0] ptg;
    logic        wbv;
    logic [3:0]  op;
    logic [15:0] pcw;
    logic        sel;
    logic [15:0] mux;
    logic        e_flush;
    logic [15:0] e_redir;
    logic        e_upd;
    logic        e_empty;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic ifv, logic [15:0] pci, logic pt, logic [15:0] ptg,
                              logic wbv, logic [3:0] op, logic [15:0] pcw, logic sel,
                              logic [15:0] mux, logic ef, logic [15:0] er, logic eu,
                              logic ee, logic [15:0] ec);
    vec_t v;
    v.ifv = ifv; v.pci = pci; v.pt = pt; v.ptg = ptg; v.wbv = wbv; v.op = op;
    v.pcw = pcw; v.sel = sel; v.mux = mux; v.e_flush = ef; v.e_redir = er;
    v.e_upd = eu; v.e_empty = ee; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    logic        ifv, pt, wbv, sel;
    logic [3:0]  op;
    logic [15:0] pci, ptg, pcw, mux;
    int          seq_pc;

    // Correct taken BR, then a wrong target, then predicted-taken ADD at 0xFFFE.
    vecs[0] = mk(1, 16'h3000, 1, 16'h3010, 0, 4'h0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    vecs[1] = mk(0, 16'h0000, 0, 16'h0000, 1, 4'h0, 16'h3000, 1, 16'h3010, 0, 16'h0000, 0, 1, 0);
    vecs[2] = mk(1, 16'h3000, 1, 16'h3010, 0, 4'h0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    vecs[3] = mk(0, 16'h0000, 0, 16'h0000, 1, 4'h0, 16'h3000, 1, 16'h3020, 1, 16'h3020, 1, 1, 1);
    vecs[4] = mk(0, 16'h0000, 0, 16'h0000, 0, 4'h0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 1);
    vecs[5] = mk(1, 16'hFFFE, 1, 16'h1234, 0, 4'h0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    vecs[6] = mk(0, 16'h0000, 0, 16'h0000, 1, 4'h1, 16'hFFFE, 0, 16'h0000, 1, 16'h0000, 0, 1, 2);
    vecs[7] = mk(0, 16'h0000, 0, 16'h0000, 0, 4'h0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 2);

    model_clear();
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_cnt", mispredict_cnt, 0);

    // table-driven directed vectors
    foreach (vecs[i]) begin
      cyc(vecs[i].ifv, vecs[i].pci, vecs[i].pt, vecs[i].ptg, vecs[i].wbv, vecs[i].op,
          vecs[i].pcw, vecs[i].sel, vecs[i].mux);
      chk($sformatf("vec%0d_flush", i), flush, vecs[i].e_flush);
      if (vecs[i].e_flush) chk($sformatf("vec%0d_redirect", i), redirect_pc, vecs[i].e_redir);
      chk($sformatf("vec%0d_btb_update", i), btb_update, vecs[i].e_upd);
      chk($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
      chk($sformatf("vec%0d_cnt", i), mispredict_cnt, vecs[i].e_cnt);
      if (i == 3) begin
        chk("vec3_update_pc", update_pc, 16'h3000);
        chk("vec3_update_target", update_target, 16'h3020);
      end
    end

    // Reset mid-flight: 3 pushes, then an asynchronous reset between edges.
    for (int i = 0; i < 3; i++) cyc(1, 16'h5000 + 16'(2*i), 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle_inputs();
    #2 reset = 1;
    #1;
    chk("async_empty", empty, 1);
    chk("async_full", full, 0);
    chk("async_flush", flush, 0);
    chk("async_redirect", redirect_pc, 0);
    chk("async_btb_update", btb_update, 0);
    chk("async_update_pc", update_pc, 0);
    chk("async_update_target", update_target, 0);
    chk("async_order_err", order_err, 0);
    chk("async_overflow", overflow, 0);
    chk("async_cnt", mispredict_cnt, 0);
    model_clear();
    @(negedge clk);
    reset = 0;

    // Fill, overflow, then a push and a pop in the same cycle while full.
    for (int i = 0; i < DEPTH; i++) cyc(1, 16'h0100 + 16'(2*i), 0, 0, 0, 0, 0, 0, 0);
    chk("fill_full", full, 1);
    cyc(1, 16'h0108, 0, 0, 0, 0, 0, 0, 0);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_full", full, 1);
    cyc(1, 16'h010A, 0, 0, 1, 4'h1, 16'h0100, 0, 0);
    chk("pushpop_full", full, 1);
    chk("pushpop_flush", flush, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 4'h1, 16'h0102 + 16'(2*i), 0, 0);
    cyc(0, 0, 0, 0, 1, 4'h1, 16'h010A, 0, 0);
    chk("drain_empty", empty, 1);
    chk("drain_order_err", order_err, 0);

    // Mispredict pop with a concurrent push and 2 younger entries behind it.
    do_reset();
    cyc(1, 16'h0200, 1, 16'h0250, 0, 0, 0, 0, 0);
    cyc(1, 16'h0202, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 16'h0204, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 16'h0300, 0, 0, 1, 4'h0, 16'h0200, 0, 16'h0202);
    chk("squash_empty", empty, 1);
    chk("squash_flush", flush, 1);
    chk("squash_redirect", redirect_pc, 16'h0202);
    chk("squash_btb_update", btb_update, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("squash_pulse_end", flush, 0);
    chk("squash_still_empty", empty, 1);
    cyc(0, 0, 0, 0, 1, 4'h1, 16'h0300, 0, 0);
    chk("empty_pop_order_err", order_err, 1);

    // Randomised traffic against the model, with an occasional reset.
    do_reset();
    seq_pc = 16'h4000;
    for (int n = 0; n < 1500; n++) begin
      if (n % 300 == 299) do_reset();
      ifv = ($urandom_range(0, 3) != 0);
      pci = 16'(seq_pc);
      if (ifv) seq_pc = seq_pc + 2;
      pt  = ($urandom_range(0, 2) == 0);
      ptg = 16'h6000 + 16'($urandom_range(0, 3) * 2);
      wbv = ($urandom_range(0, 2) != 0);
      op  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      sel = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 15) != 0) pcw = mq[0].pc;
      else pcw = 16'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) mux = mq[0].target;
      else mux = 16'h6000 + 16'($urandom_range(0, 3) * 2);
      cyc(ifv, pci, pt, ptg, wbv, op, pcw, sel, mux);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
